// File: rtl/issue_scheduler.sv
// Issue stage: steers renamed ops into arith/mem/term FIFOs, tracks register readiness,
// issues each class head in order. Define ISSUE_BYPASS_EN to forward writebacks into the ready check.
`ifndef PR_ADDR_W
`define PR_ADDR_W 5
`endif
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 38
`endif

module issue_scheduler #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned NUM_WB      = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [`RENAMED_OP_SZ-1:0]       in_instr,
  input  logic [1:0]                      in_class,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [`RENAMED_OP_SZ-1:0]       arith_instr,
  output logic                            arith_valid,
  input  logic                            arith_ready,
  output logic [`RENAMED_OP_SZ-1:0]       mem_instr,
  output logic                            mem_valid,
  input  logic                            mem_ready,
  output logic [`RENAMED_OP_SZ-1:0]       term_instr,
  output logic                            term_valid,
  input  logic                            term_ready,
  input  logic [`PR_ADDR_W*NUM_WB-1:0]    wb_phys_regs,
  input  logic [NUM_WB-1:0]               wb_enable,
  input  logic                            flush
);

  localparam int unsigned OPW  = `RENAMED_OP_SZ;
  localparam int unsigned PW   = `PR_ADDR_W;
  localparam int unsigned NREG = 1 << PW;
  localparam int unsigned AW   = $clog2(QUEUE_DEPTH);
  localparam int unsigned NCLS = 3;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [NREG-1:0] sb, sb_next, avail;
  logic [OPW-1:0]  q_mem [NCLS][QUEUE_DEPTH];
  logic [AW:0]     head [NCLS];
  logic [AW:0]     tail [NCLS];
  logic [OPW-1:0]  out_instr [NCLS];
  logic [NCLS-1:0] out_valid, out_ready, out_free;
  logic [NCLS-1:0] empty, full, pop, push, direct, sel;
  logic            in_legal, enq, in_srcs_ok;
  logic [PW-1:0]   dst_v, dst_f;

  function automatic logic srcs_ready(input logic [OPW-1:0] op, input logic [NREG-1:0] rdy);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!rdy[op[8 + i*PW +: PW]]) ok = 1'b0;
    end
    return ok;
  endfunction

  assign out_ready   = {term_ready, mem_ready, arith_ready};
  assign arith_instr = out_instr[0];
  assign mem_instr   = out_instr[1];
  assign term_instr  = out_instr[2];
  assign arith_valid = out_valid[0];
  assign mem_valid   = out_valid[1];
  assign term_valid  = out_valid[2];

  assign dst_v = in_instr[28 +: PW];
  assign dst_f = in_instr[33 +: PW];

  always_comb begin
    avail = sb;
`ifdef ISSUE_BYPASS_EN
    for (int unsigned k = 0; k < NUM_WB; k++) begin
      if (wb_enable[k]) avail[wb_phys_regs[k*PW +: PW]] = 1'b1;
    end
`endif
    avail[0] = 1'b1;
  end

  always_comb begin
    in_legal = (in_class != 2'd3);
    sel      = in_legal ? (3'b001 << in_class) : '0;
    for (int unsigned c = 0; c < NCLS; c++) begin
      empty[c]    = (head[c] == tail[c]);
      full[c]     = (head[c][AW] != tail[c][AW]) && (head[c][AW-1:0] == tail[c][AW-1:0]);
      out_free[c] = !out_valid[c] || out_ready[c];
      pop[c]      = !flush && !empty[c] && out_free[c]
                    && srcs_ready(q_mem[c][head[c][AW-1:0]], avail);
    end
    // A full FIFO still takes the op when its head is leaving this same cycle.
    in_ready   = !flush && (!in_legal || |(sel & (~full | pop)));
    enq        = in_valid && in_ready && in_legal;
    in_srcs_ok = srcs_ready(in_instr, avail);
    for (int unsigned c = 0; c < NCLS; c++) begin
      // Empty FIFO with a free output register: skip the FIFO to issue the next cycle.
      direct[c] = enq && sel[c] && empty[c] && in_srcs_ok && out_free[c];
      push[c]   = enq && sel[c] && !direct[c];
    end
  end

  always_comb begin
    sb_next = sb;
    for (int unsigned k = 0; k < NUM_WB; k++) begin
      if (wb_enable[k]) sb_next[wb_phys_regs[k*PW +: PW]] = 1'b1;
    end
    if (enq) begin
      if (dst_v != '0) sb_next[dst_v] = 1'b0;
      if (dst_f != '0) sb_next[dst_f] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb <= '1;
      for (int unsigned c = 0; c < NCLS; c++) begin
        head[c]      <= '0;
        tail[c]      <= '0;
        out_valid[c] <= 1'b0;
        out_instr[c] <= '0;
      end
    end else if (flush) begin
      sb <= '1;
      for (int unsigned c = 0; c < NCLS; c++) begin
        head[c]      <= '0;
        tail[c]      <= '0;
        out_valid[c] <= 1'b0;
      end
    end else begin
      sb <= sb_next;
      for (int unsigned c = 0; c < NCLS; c++) begin
        if (push[c]) begin
          q_mem[c][tail[c][AW-1:0]] <= in_instr;
          tail[c] <= tail[c] + PTR_ONE;
        end
        if (pop[c]) begin
          head[c]      <= head[c] + PTR_ONE;
          out_instr[c] <= q_mem[c][head[c][AW-1:0]];
          out_valid[c] <= 1'b1;
        end else if (direct[c]) begin
          out_instr[c] <= in_instr;
          out_valid[c] <= 1'b1;
        end else if (out_ready[c]) begin
          out_valid[c] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: per-class expected-op queues plus directed timing checks.
module tb_issue_scheduler;

  localparam int unsigned OPW = 38;
  localparam int unsigned PW  = 5;
  localparam int unsigned NWB = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [OPW-1:0]  in_instr;
  logic [1:0]      in_class;
  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  arith_instr, mem_instr, term_instr;
  logic            arith_valid, mem_valid, term_valid;
  logic            arith_ready, mem_ready, term_ready;
  logic [PW*NWB-1:0] wb_phys_regs;
  logic [NWB-1:0]  wb_enable;
  logic            flush;

  int checks   = 0;
  int failures = 0;
  logic [OPW-1:0] exp_q [3][$];

  issue_scheduler #(.QUEUE_DEPTH(4), .NUM_WB(NWB)) dut (
    .clk(clk), .rst(rst),
    .in_instr(in_instr), .in_class(in_class), .in_valid(in_valid), .in_ready(in_ready),
    .arith_instr(arith_instr), .arith_valid(arith_valid), .arith_ready(arith_ready),
    .mem_instr(mem_instr), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .term_instr(term_instr), .term_valid(term_valid), .term_ready(term_ready),
    .wb_phys_regs(wb_phys_regs), .wb_enable(wb_enable), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [OPW-1:0] mkop(input logic [7:0] tag, input logic [4:0] s0, input logic [4:0] s1,
                                          input logic [4:0] dv, input logic [4:0] df);
    logic [OPW-1:0] op;
    op = '0;
    op[7:0]   = tag;
    op[8 +: 5]  = s0;
    op[13 +: 5] = s1;
    op[18 +: 5] = 5'd0;
    op[23 +: 5] = 5'd0;
    op[28 +: 5] = dv;
    op[33 +: 5] = df;
    return op;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] cls, input logic [OPW-1:0] op);
    in_valid = 1'b1;
    in_class = cls;
    in_instr = op;
  endtask

  // Handshakes fire at the next posedge; compare against the oldest expected op per class.
  always @(negedge clk) begin
    logic [2:0] v, r;
    logic [OPW-1:0] o [3];
    v = {term_valid, mem_valid, arith_valid};
    r = {term_ready, mem_ready, arith_ready};
    o[0] = arith_instr; o[1] = mem_instr; o[2] = term_instr;
    for (int c = 0; c < 3; c++) begin
      if (v[c] && r[c]) begin
        if (exp_q[c].size() == 0) chk($sformatf("spurious_issue_c%0d", c), 1, 0);
        else chk($sformatf("issue_data_c%0d", c), o[c], exp_q[c].pop_front());
      end
    end
    if (rst || flush) begin
      for (int c = 0; c < 3; c++) exp_q[c].delete();
    end else if (in_valid && in_ready && in_class != 2'd3) begin
      exp_q[in_class].push_back(in_instr);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_class = 2'd0; in_instr = '0;
    arith_ready = 1'b1; mem_ready = 1'b1; term_ready = 1'b1;
    wb_enable = '0; wb_phys_regs = '0;
    tick; tick;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_valids", {arith_valid, mem_valid, term_valid}, 0);
    chk("rst_instrs", arith_instr | mem_instr | term_instr, 0);
    chk("rst_sb", dut.sb, 32'hFFFF_FFFF);

    // Ready sources: issue the cycle after enqueue, dest 7 marked busy.
    drive(2'd0, mkop(8'h01, 5'd0, 5'd0, 5'd7, 5'd0));
    tick;
    in_valid = 1'b0;
    chk("first_issue_valid", arith_valid, 1);
    chk("first_issue_instr", arith_instr, mkop(8'h01, 5'd0, 5'd0, 5'd7, 5'd0));
    chk("sb7_busy", dut.sb[7], 0);

    // Dependent op waits on reg 7 until writeback port 4.
    drive(2'd0, mkop(8'h02, 5'd7, 5'd0, 5'd8, 5'd0));
    tick;
    in_valid = 1'b0;
    tick; chk("dep_wait1", arith_valid, 0);
    tick; chk("dep_wait2", arith_valid, 0);
    wb_enable = 5'b10000;
    wb_phys_regs[4*PW +: PW] = 5'd7;
    tick;
    wb_enable = '0;
`ifdef ISSUE_BYPASS_EN
    chk("dep_wb_t1", arith_valid, 1);
    tick; chk("dep_wb_t2", arith_valid, 0);
`else
    chk("dep_wb_t1", arith_valid, 0);
    tick; chk("dep_wb_t2", arith_valid, 1);
`endif
    chk("sb8_busy", dut.sb[8], 0);
    wb_enable = 5'b00001;
    wb_phys_regs[0 +: PW] = 5'd8;
    tick;
    wb_enable = '0;
    chk("sb_after_wb", dut.sb, 32'hFFFF_FFFF);

    // Term backpressure: output register + 4 FIFO entries, then only class 2 stalls.
    term_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(2'd2, mkop(8'h10 + 8'(i), 5'd0, 5'd0, 5'd0, 5'd0));
      #1;
      chk("term_fill_ready", in_ready, 1);
      tick;
    end
    drive(2'd2, mkop(8'h1F, 5'd0, 5'd0, 5'd0, 5'd0));
    #1;
    chk("term_full_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      drive(2'd0, mkop(8'h20 + 8'(i), 5'd1, 5'd2, 5'd0, 5'd0));
      #1;
      chk("arith_while_term_full", in_ready, 1);
      tick;
      chk("arith_streams", arith_valid, 1);
    end
    in_valid = 1'b0;
    term_ready = 1'b1;
    in_class = 2'd2;
    #1;
    chk("term_pop_credit", in_ready, 1);
    for (int i = 0; i < 7; i++) tick;
    chk("term_drained", term_valid, 0);
    chk("term_q_empty", exp_q[2].size(), 0);

    // Same-cycle destination clear beats writeback set.
    drive(2'd0, mkop(8'h30, 5'd0, 5'd0, 5'd9, 5'd0));
    wb_enable = 5'b00001;
    wb_phys_regs[0 +: PW] = 5'd9;
    tick;
    in_valid = 1'b0;
    wb_enable = '0;
    chk("clear_wins_sb9", dut.sb[9], 0);

    // Blocked mem ops plus a stalled arith output, then flush.
    drive(2'd0, mkop(8'h40, 5'd0, 5'd0, 5'd12, 5'd13));
    tick;
    for (int i = 0; i < 3; i++) begin
      drive(2'd1, mkop(8'h41 + 8'(i), 5'd12, 5'd0, 5'd0, 5'd0));
      tick;
    end
    in_valid = 1'b0;
    chk("mem_blocked", mem_valid, 0);
    arith_ready = 1'b0;
    drive(2'd0, mkop(8'h50, 5'd0, 5'd0, 5'd0, 5'd0));
    tick;
    in_valid = 1'b0;
    chk("arith_stalled", arith_valid, 1);
    flush = 1'b1;
    drive(2'd1, mkop(8'h51, 5'd0, 5'd0, 5'd3, 5'd0));
    #1;
    chk("flush_in_ready", in_ready, 0);
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    arith_ready = 1'b1;
    chk("flush_valids", {arith_valid, mem_valid, term_valid}, 0);
    chk("flush_sb", dut.sb, 32'hFFFF_FFFF);
    tick;
    chk("flush_no_stale_mem", mem_valid, 0);
    drive(2'd1, mkop(8'h60, 5'd12, 5'd0, 5'd0, 5'd0));
    tick;
    in_valid = 1'b0;
    chk("post_flush_mem_issue", mem_valid, 1);
    tick;

    // Illegal class is dropped entirely.
    drive(2'd3, mkop(8'h70, 5'd0, 5'd0, 5'd15, 5'd16));
    tick;
    in_valid = 1'b0;
    chk("class3_valids", {arith_valid, mem_valid, term_valid}, 0);
    chk("class3_sb", dut.sb, 32'hFFFF_FFFF);
    tick; tick;

    for (int c = 0; c < 3; c++) chk($sformatf("final_q_empty_c%0d", c), exp_q[c].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
